// File: rtl/fx_div_pkg.sv
// Shared types and constants for the fixed-point divider (fx_divider, fx_div_ucore).
package fx_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } fx_div_state_e;

   // Largest / smallest signed value of a w-bit two's complement word.
   function automatic logic signed [63:0] fx_max_q(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] fx_min_q(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/fx_divider_if.sv
// Operand/result handshake bundle of the fixed-point divider.
interface fx_divider_if #(
   parameter int D_W = 16
);
   logic           in_vld;
   logic           in_rdy;
   logic [D_W-1:0] dividend;
   logic [D_W-1:0] divisor;
   logic           out_vld;
   logic           out_rdy;
   logic [D_W-1:0] quotient;
   logic           div_zero;
   logic           overflow;

   modport master (
      output in_vld, dividend, divisor, out_rdy,
      input  in_rdy, out_vld, quotient, div_zero, overflow
   );

   modport slave (
      input  in_vld, dividend, divisor, out_rdy,
      output in_rdy, out_vld, quotient, div_zero, overflow
   );
endinterface

// File: rtl/fx_div_ucore.sv
// Unsigned restoring divider core: one quotient bit per step over the
// (D_W+FRAC_W)-bit numerator |dividend|<<FRAC_W, divided by |divisor|.
module fx_div_ucore #(
   parameter int D_W    = 16,
   parameter int FRAC_W = 13
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic                  step_i,
   input  logic [D_W-1:0]        dvd_mag_i,
   input  logic [D_W-1:0]        dvs_mag_i,
   output logic                  last_o,
   output logic [D_W+FRAC_W-1:0] quot_o
);
   localparam int NUM_W = D_W + FRAC_W;
   localparam int CNT_W = $clog2(NUM_W + 1);

   logic [NUM_W-1:0] num_q, num_d;
   logic [D_W-1:0]   rem_q, rem_d;
   logic [D_W-1:0]   dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [D_W:0]     trial;
   logic [D_W:0]     diff;
   logic             ge;

   // The numerator register shifts left each step and fills with quotient bits.
   always_comb begin
      trial = {rem_q, num_q[NUM_W-1]};
      diff  = trial - {1'b0, dvs_q};
      ge    = (trial >= {1'b0, dvs_q});
      num_d = num_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      if (load_i) begin
         num_d = NUM_W'(dvd_mag_i) << FRAC_W;
         rem_d = '0;
         dvs_d = dvs_mag_i;
         cnt_d = '0;
      end else if (step_i) begin
         num_d = {num_q[NUM_W-2:0], ge};
         rem_d = D_W'(ge ? diff : trial);
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         num_q <= num_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == CNT_W'(NUM_W - 1));
   assign quot_o = num_q;

endmodule

// File: rtl/fx_divider.sv
// Signed fixed-point divider: handshake FSM, sign and range handling around fx_div_ucore.
// Define FX_DIV_SATURATE_EN to clamp overflowed quotients instead of wrapping them.
module fx_divider
   import fx_div_pkg::*;
#(
   parameter int D_W    = 16,
   parameter int FRAC_W = 13
) (
   input  logic           I_CLK,
   input  logic           I_RST,
   input  logic           I_IN_VLD,
   output logic           O_IN_RDY,
   input  logic [D_W-1:0] I_DIVIDEND,
   input  logic [D_W-1:0] I_DIVISOR,
   output logic           O_OUT_VLD,
   input  logic           I_OUT_RDY,
   output logic [D_W-1:0] O_QUOTIENT,
   output logic           O_DIV_ZERO,
   output logic           O_OVERFLOW
);
   localparam int NUM_W = D_W + FRAC_W;

   localparam logic [D_W-1:0]   MAX_Q   = D_W'(fx_max_q(D_W));
   localparam logic [D_W-1:0]   MIN_Q   = D_W'(fx_min_q(D_W));
   localparam logic [NUM_W-1:0] POS_LIM = NUM_W'(fx_max_q(D_W));
   localparam logic [NUM_W-1:0] NEG_LIM = NUM_W'(-fx_min_q(D_W));

   fx_div_state_e    state_q, state_d;
   logic             neg_q, neg_d;
   logic [D_W-1:0]   quot_q, quot_d;
   logic             dz_q, dz_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic             dvs_zero;
   logic [D_W-1:0]   dvd_mag;
   logic [D_W-1:0]   dvs_mag;
   logic             core_last;
   logic [NUM_W-1:0] q_mag;
   logic             q_neg;
   logic [D_W-2:0]   mag_lo;
   logic [D_W-2:0]   res_lo;
   logic             fix_ovf;
   logic [D_W-1:0]   fix_quot;

   assign accept   = I_IN_VLD && (state_q == ST_IDLE);
   assign dvs_zero = (I_DIVISOR == '0);
   assign dvd_mag  = I_DIVIDEND[D_W-1] ? (~I_DIVIDEND + D_W'(1)) : I_DIVIDEND;
   assign dvs_mag  = I_DIVISOR[D_W-1]  ? (~I_DIVISOR + D_W'(1))  : I_DIVISOR;

   fx_div_ucore #(
      .D_W    (D_W),
      .FRAC_W (FRAC_W)
   ) u_core (
      .clk       (I_CLK),
      .rst       (I_RST),
      .load_i    (accept && !dvs_zero),
      .step_i    (state_q == ST_CALC),
      .dvd_mag_i (dvd_mag),
      .dvs_mag_i (dvs_mag),
      .last_o    (core_last),
      .quot_o    (q_mag)
   );

   // A zero magnitude is never negative; the low bits of Qfull only need the
   // low bits of the magnitude, the sign bit comes from q_neg.
   always_comb begin
      q_neg   = neg_q && (q_mag != '0);
      mag_lo  = q_mag[D_W-2:0];
      res_lo  = q_neg ? (~mag_lo + (D_W-1)'(1)) : mag_lo;
      fix_ovf = q_neg ? (q_mag > NEG_LIM) : (q_mag > POS_LIM);
`ifdef FX_DIV_SATURATE_EN
      fix_quot = fix_ovf ? (q_neg ? MIN_Q : MAX_Q) : {q_neg, res_lo};
`else
      fix_quot = {q_neg, res_lo};
`endif
   end

   // NOTE: every next-state signal gets its default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      neg_d   = neg_q;
      quot_d  = quot_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (I_IN_VLD) begin
               neg_d = I_DIVIDEND[D_W-1] ^ I_DIVISOR[D_W-1];
               ovf_d = 1'b0;
               if (dvs_zero) begin
                  state_d = ST_DONE;
                  dz_d    = 1'b1;
                  quot_d  = I_DIVIDEND[D_W-1] ? MIN_Q : MAX_Q;
               end else begin
                  state_d = ST_CALC;
                  dz_d    = 1'b0;
               end
            end
         end
         ST_CALC: begin
            if (core_last) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_DONE;
            quot_d  = fix_quot;
            ovf_d   = fix_ovf;
         end
         ST_DONE: begin
            if (I_OUT_RDY) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; the datapath registers are cleared on reset as well.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state_q <= ST_IDLE;
         neg_q   <= 1'b0;
         quot_q  <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         neg_q   <= neg_d;
         quot_q  <= quot_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign O_IN_RDY   = (state_q == ST_IDLE);
   assign O_OUT_VLD  = (state_q == ST_DONE);
   assign O_QUOTIENT = quot_q;
   assign O_DIV_ZERO = dz_q;
   assign O_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_fx_divider.sv
// Scoreboard bench for fx_divider (D_W=16, FRAC_W=13); latency is counted with the accept edge as edge 1.
module tb_fx_divider;
   localparam int D_W    = 16;
   localparam int FRAC_W = 13;

`ifdef FX_DIV_SATURATE_EN
   localparam logic [15:0] Q_7FFF_P1 = 16'h7FFF;
   localparam logic [15:0] Q_8000_M1 = 16'h7FFF;
   localparam logic [15:0] Q_7FFF_M1 = 16'h8000;
`else
   localparam logic [15:0] Q_7FFF_P1 = 16'h6000;
   localparam logic [15:0] Q_8000_M1 = 16'h0000;
   localparam logic [15:0] Q_7FFF_M1 = 16'hA000;
`endif

   typedef struct packed {
      logic [15:0] q;
      logic        dz;
      logic        ovf;
      logic [31:0] acc_cyc;
      logic [7:0]  lat;
      logic [15:0] id;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   fx_divider_if #(.D_W(D_W)) bus ();

   fx_divider #(
      .D_W    (D_W),
      .FRAC_W (FRAC_W)
   ) dut (
      .I_CLK      (clk),
      .I_RST      (rst),
      .I_IN_VLD   (bus.in_vld),
      .O_IN_RDY   (bus.in_rdy),
      .I_DIVIDEND (bus.dividend),
      .I_DIVISOR  (bus.divisor),
      .O_OUT_VLD  (bus.out_vld),
      .I_OUT_RDY  (bus.out_rdy),
      .O_QUOTIENT (bus.quotient),
      .O_DIV_ZERO (bus.div_zero),
      .O_OVERFLOW (bus.overflow)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   n_sent = 0;
   bit   rdy_auto = 1'b1;
   bit   rdy_rand = 1'b0;
   bit   seen_first = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: Qfull = trunc((a * 2^13) / b) in 64-bit signed arithmetic.
   function automatic exp_t model(input logic signed [15:0] a, input logic signed [15:0] b);
      exp_t   e;
      longint qf;
      e = '0;
      if (b == 16'sd0) begin
         e.dz  = 1'b1;
         e.q   = (a < 0) ? 16'h8000 : 16'h7FFF;
         e.lat = 8'd1;
      end else begin
         qf    = (longint'(a) * 64'sd8192) / longint'(b);
         e.ovf = (qf > 64'sd32767) || (qf < -64'sd32768);
`ifdef FX_DIV_SATURATE_EN
         if (qf > 64'sd32767)       e.q = 16'h7FFF;
         else if (qf < -64'sd32768) e.q = 16'h8000;
         else                       e.q = qf[15:0];
`else
         e.q = {qf[63], qf[14:0]};
`endif
         e.lat = 8'd31;
      end
      return e;
   endfunction

   task automatic push_exp(input logic [15:0] q, input logic dz, input logic ovf, input int lat);
      exp_t e;
      e.q       = q;
      e.dz      = dz;
      e.ovf     = ovf;
      e.lat     = 8'(lat);
      e.acc_cyc = 32'(cyc);
      e.id      = 16'(n_sent);
      n_sent++;
      sb.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                       input logic dz, input logic ovf, input int lat);
      bit r;
      int waited;
      r = 1'b0;
      waited = 0;
      bus.dividend = a;
      bus.divisor  = b;
      bus.in_vld   = 1'b1;
      while (!r && waited < 200) begin
         @(negedge clk);
         r = bus.in_rdy;
         @(posedge clk);
         waited++;
      end
      #1;
      if (!r) check("accept_timeout", 32'd0, 32'd1);
      else    push_exp(q, dz, ovf, lat);
      bus.in_vld = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 500) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: compares the head of the scoreboard every cycle the result is valid.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_vld) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = sb[0];
               if (!seen_first) begin
                  check($sformatf("latency#%0d", e.id), 32'(cyc - int'(e.acc_cyc) + 1), 32'(e.lat));
                  seen_first = 1'b1;
               end
               check($sformatf("quotient#%0d", e.id), 32'(bus.quotient), 32'(e.q));
               check($sformatf("div_zero#%0d", e.id), 32'(bus.div_zero), 32'(e.dz));
               check($sformatf("overflow#%0d", e.id), 32'(bus.overflow), 32'(e.ovf));
               if (bus.out_rdy) begin
                  void'(sb.pop_front());
                  seen_first = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_auto) bus.out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #5_000_000;
      check("watchdog_expired", 32'd1, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      exp_t m;
      logic [15:0] a, b;
      int   w;

      rst          = 1'b1;
      bus.in_vld   = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      bus.out_rdy  = 1'b1;
      #12;
      check("rst_in_rdy",   32'(bus.in_rdy),   32'd1);
      check("rst_out_vld",  32'(bus.out_vld),  32'd0);
      check("rst_quotient", 32'(bus.quotient), 32'd0);
      check("rst_div_zero", 32'(bus.div_zero), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);

      // Operands presented as reset falls are taken on the very next edge.
      @(negedge clk);
      bus.dividend = 16'h2000;
      bus.divisor  = 16'h4000;
      bus.in_vld   = 1'b1;
      rst          = 1'b0;
      @(posedge clk);
      #1;
      check("accept_after_reset", 32'(bus.in_rdy), 32'd0);
      push_exp(16'h1000, 1'b0, 1'b0, 31);
      bus.in_vld = 1'b0;
      drain();

      // Directed vectors: a, b, quotient, div_zero, overflow, latency.
      send(16'hE000, 16'h4000, 16'hF000,  1'b0, 1'b0, 31);
      send(16'h7FFF, 16'h0001, Q_7FFF_P1, 1'b0, 1'b1, 31);
      send(16'h8000, 16'hFFFF, Q_8000_M1, 1'b0, 1'b1, 31);
      send(16'h0064, 16'h0000, 16'h7FFF,  1'b1, 1'b0, 1);
      send(16'hFF9C, 16'h0000, 16'h8000,  1'b1, 1'b0, 1);
      send(16'h0000, 16'h0000, 16'h7FFF,  1'b1, 1'b0, 1);
      send(16'h4000, 16'hE000, 16'hC000,  1'b0, 1'b0, 31);
      send(16'h0001, 16'h0003, 16'h0AAA,  1'b0, 1'b0, 31);
      send(16'hFFFF, 16'h0003, 16'hF556,  1'b0, 1'b0, 31);
      send(16'h0000, 16'hFFFB, 16'h0000,  1'b0, 1'b0, 31);
      send(16'hFFFF, 16'h7FFF, 16'h0000,  1'b0, 1'b0, 31);
      send(16'h8000, 16'h2000, 16'h8000,  1'b0, 1'b0, 31);
      send(16'h7FFF, 16'h2000, 16'h7FFF,  1'b0, 1'b0, 31);
      send(16'h8000, 16'h0001, 16'h8000,  1'b0, 1'b1, 31);
      send(16'h7FFF, 16'hFFFF, Q_7FFF_M1, 1'b0, 1'b1, 31);
      send(16'h8000, 16'h8000, 16'h2000,  1'b0, 1'b0, 31);
      drain();

      // Hold the result for 5 cycles while new operands wait.
      rdy_auto    = 1'b0;
      bus.out_rdy = 1'b0;
      send(16'h1000, 16'h6000, 16'h0555, 1'b0, 1'b0, 31);
      w = 0;
      while (!bus.out_vld && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("stall_reached_done", 32'(bus.out_vld), 32'd1);
      bus.dividend = 16'h2000;
      bus.divisor  = 16'h4000;
      bus.in_vld   = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("stall_in_rdy", 32'(bus.in_rdy), 32'd0);
         @(posedge clk);
         #1;
      end
      bus.out_rdy = 1'b1;
      @(posedge clk);
      #1;
      check("release_out_vld",   32'(bus.out_vld), 32'd0);
      check("release_no_accept", 32'(bus.in_rdy),  32'd1);
      @(posedge clk);
      #1;
      check("accept_after_release", 32'(bus.in_rdy), 32'd0);
      push_exp(16'h1000, 1'b0, 1'b0, 31);
      bus.in_vld = 1'b0;
      rdy_auto   = 1'b1;
      drain();

      // Reset in the middle of CALC abandons the division.
      send(16'h7000, 16'h0100, 16'h0000, 1'b0, 1'b0, 31);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_in_rdy",   32'(bus.in_rdy),   32'd1);
      check("midrst_out_vld",  32'(bus.out_vld),  32'd0);
      check("midrst_quotient", 32'(bus.quotient), 32'd0);
      check("midrst_div_zero", 32'(bus.div_zero), 32'd0);
      check("midrst_overflow", 32'(bus.overflow), 32'd0);
      sb.delete();
      seen_first = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      send(16'hE000, 16'h6000, 16'hF556, 1'b0, 1'b0, 31);
      drain();

      // Random operands with random gaps and backpressure.
      rdy_rand = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom);
         if ($urandom_range(0, 15) == 0) a = 16'h8000;
         case ($urandom_range(0, 9))
            0:       b = 16'h0000;
            1:       b = 16'($urandom_range(1, 3));
            2:       b = 16'hFFFF;
            3:       b = 16'($urandom_range(1, 255)) ^ 16'hFFFF;
            default: b = 16'($urandom);
         endcase
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         m = model(a, b);
         send(a, b, m.q, m.dz, m.ovf, int'(m.lat));
      end
      drain();
      rdy_rand = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
